if_de_queue: RTL

IF_DE_QUEUE -- requirements
Module: if_de_queue

---
 rtl/if_de_queue_pkg.sv | 27 ++
 rtl/if_de_queue_fifo_regfile.sv | 34 +++
 rtl/if_de_queue.sv | 96 +++++++++
 3 files changed

// File: rtl/if_de_queue_pkg.sv
//==============================================================================
// Module      : if_de_queue_pkg
// Description : Shared CPU field widths, constants and the fetch-entry layout
//               carried between the fetch and decode stages.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package if_de_queue_pkg;

    localparam int          PC_W     = 32;
    localparam int          INST_W   = 32;
    localparam int          EXC_W    = 5;
    localparam logic [4:0]  EXC_ADEL = 5'h04;
    localparam logic [31:0] NOP      = 32'h0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [EXC_W-1:0]  exccode;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

`default_nettype wire

// File: rtl/if_de_queue_fifo_regfile.sv
//==============================================================================
// Module      : fifo_regfile
// Description : DEPTH x WIDTH flop array, one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_regfile #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 69,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/if_de_queue.sv
//==============================================================================
// Module      : if_de_queue
// Description : Fetch-to-decode skid queue with flush; handshake outputs are
//               derived from registered occupancy only.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_de_queue
    import if_de_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    input  logic [EXC_W-1:0]         in_exccode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [EXC_W-1:0]         out_exccode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_wr_entry;
    fetch_entry_t w_rd_entry;

    // Ready/valid come only from r_count, so a full queue refuses a push
    // even when the head is being popped in the same cycle.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);

    assign w_push = in_valid  && in_ready  && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    assign w_wr_entry.pc      = in_pc;
    assign w_wr_entry.inst    = in_inst;
    assign w_wr_entry.exccode = in_exccode;

    fifo_regfile #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENTRY_W),
        .ADDR_W (c_PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_tail),
        .wdata (w_wr_entry),
        .raddr (r_head),
        .rdata (w_rd_entry)
    );

    // Stale storage is masked while empty so decode sees a clean NOP.
    assign out_pc      = out_valid ? w_rd_entry.pc      : '0;
    assign out_inst    = out_valid ? w_rd_entry.inst    : NOP;
    assign out_exccode = out_valid ? w_rd_entry.exccode : '0;
    assign count       = r_count;

endmodule

`default_nettype wire
